// File: rtl/ram_bank_pkg.sv
// Shared definitions for the ram_bank storage block: sweep FSM encoding and
// default geometry.
package ram_bank_pkg;

    typedef enum logic {
        RB_ST_CLEAR = 1'b0,
        RB_ST_IDLE  = 1'b1
    } rb_state_e;

    localparam int RB_WIDTH_DEF = 16;
    localparam int RB_DEPTH_DEF = 8;

endpackage : ram_bank_pkg

// File: rtl/ram_bank_clr_seq.sv
// Clear-sweep sequencer for ram_bank: walks the sweep counter over every word
// after reset or on a clr request and raises busy while doing so.
module ram_bank_clr_seq
    import ram_bank_pkg::*;
#(
    parameter  int DEPTH  = RB_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rb_state_e         state;
    rb_state_e         state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RB_ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RB_ST_CLEAR: begin
                if (clr) begin
                    cnt_next = '0;
                end else if (cnt == LAST_ADDR) begin
                    state_next = RB_ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ADDR_W'(1);
                end
            end
            RB_ST_IDLE: begin
                if (clr) begin
                    state_next = RB_ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = RB_ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state == RB_ST_CLEAR);
        clr_we   = (state == RB_ST_CLEAR);
        clr_addr = cnt;
    end

endmodule : ram_bank_clr_seq

// File: rtl/ram_bank.sv
// Parametrised storage bank: one synchronous write port, one registered read
// port, self-clearing sweep. Define READ_BYPASS_EN for same-address write-to-read forwarding.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter  int WIDTH  = RB_WIDTH_DEF,
    parameter  int DEPTH  = RB_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [WIDTH-1:0]  in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr_r,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              access_ok;
    logic              user_we;
    logic              rd_hit;
    logic              rd_in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  rd_data;

    ram_bank_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clr edge taken from IDLE also blocks user traffic on that same edge.
    always_comb begin
        access_ok   = !busy && !clr;
        user_we     = access_ok && load && ({1'b0, addr_w} < DEPTH_X);
        rd_hit      = access_ok && rd_en;
        rd_in_range = ({1'b0, addr_r} < DEPTH_X);
    end

    // Sweep and user writes are mutually exclusive because user_we needs !busy.
    always_comb begin
        wr_en   = (clr_we && rst_n) || user_we;
        wr_addr = clr_we ? clr_addr : addr_w;
        wr_data = clr_we ? '0 : in;
    end

    // NOTE: the array has no reset; the clear sweep zeroes it so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[addr_r];
        end
`ifdef READ_BYPASS_EN
        if (user_we && (addr_w == addr_r)) begin
            rd_data = in;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_hit;
            if (rd_hit) begin
                out <= rd_data;
            end
        end
    end

endmodule : ram_bank
